msrv32_ifetch_buffer: RTL and testbench
=======================================

MSRV32_IFETCH_BUFFER -- requirements
Module: msrv32_ifetch_buffer

Interface
REQ-001 Parameter BOOT_ADDRESS, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, instruction buffer entries; fixed at 2.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset; asynchronous, active-low.
REQ-005 iaddr_in  input  32  next fetch address from the PC mux.
REQ-006 flush_in  input  1  redirect request (branch taken / trap / mret); iaddr_in holds the redirect target in the same cycle.
REQ-007 fetch_pc_out  output  32  address currently being fetched; drives the PC mux pc_in.
REQ-008 ahb_ready_out  output  1  one-cycle pulse: fetch address advanced; drives the PC mux ahb_ready_in.
REQ-009 imem_req_out  output  1  instruction-memory transfer request.
REQ-010 imem_addr_out  output  32  transfer address; equals fetch_pc_out.
REQ-011 imem_ready_in  input  1  transfer completes in a cycle with imem_req_out=1 and imem_ready_in=1.
REQ-012 imem_rdata_in  input  32  instruction word; valid on completion.
REQ-013 imem_err_in  input  1  bus error; valid on completion.
REQ-014 instr_out  output  32  head-entry instruction to decode.
REQ-015 pc_out  output  32  head-entry instruction address.
REQ-016 fault_out  output  1  head-entry access fault (bus error or fetch_pc[1:0]!=0).
REQ-017 instr_valid_out  output  1  head entry valid.
REQ-018 instr_ready_in  input  1  decode accepts head when instr_valid_out=1 and instr_ready_in=1.

Function
REQ-019 States: IDLE, FETCH, WAIT_SPACE, DRAIN; registered next-state logic.
REQ-020 IDLE: entered on reset; one cycle, then FETCH with fetch_pc=BOOT_ADDRESS, imem_req_out=0.
REQ-021 FETCH: imem_req_out=1; imem_addr_out stable until completion.
REQ-022 Completion in FETCH without flush: push {fetch_pc, rdata, err|fetch_pc[1:0]!=0}; fetch_pc<=iaddr_in; ahb_ready_out=1 that cycle.
REQ-023 After completion, next state FETCH if post-push/pop count<2, else WAIT_SPACE.
REQ-024 WAIT_SPACE: imem_req_out=0; returns to FETCH the cycle after a pop leaves count<2.
REQ-025 Misaligned fetch_pc ([1:0]!=0): no bus request; entry pushed immediately with fault=1, instr=32'h0000_0013, treated as a completion.
REQ-026 Buffer: 2-entry FIFO, 2-bit count 0..2; push and pop in the same cycle leave count unchanged; pointers wrap modulo 2.
REQ-027 Push when count=2 never occurs; pop when count=0 ignored.
REQ-028 Outputs instr_out/pc_out/fault_out show head entry; zero when count=0.
REQ-029 Flush in IDLE/WAIT_SPACE/FETCH-with-completion: FIFO cleared (count=0), completion data discarded, fetch_pc<=iaddr_in, ahb_ready_out=1, next state FETCH.
REQ-030 Flush in FETCH without completion: FIFO cleared; iaddr_in captured in redirect register; next state DRAIN.
REQ-031 DRAIN: imem_req_out=1 on old address until completion; data discarded, no push; on completion fetch_pc<=redirect, ahb_ready_out=1, next FETCH.
REQ-032 Flush in DRAIN: redirect register overwritten with new iaddr_in; remain DRAIN.
REQ-033 Flush has priority over pop: decode acceptance in a flush cycle has no effect.
REQ-034 ahb_ready_out is 0 in every cycle not named in REQ-022, REQ-025, REQ-029, REQ-031.

Reset
REQ-035 rst_in=0 asynchronously forces: state IDLE, fetch_pc=BOOT_ADDRESS, count=0, pointers=0, redirect=0, all outputs 0 except fetch_pc_out/imem_addr_out=BOOT_ADDRESS.
REQ-036 Reset asserted mid-transfer abandons it; no push follows reset release.
REQ-037 Reset deassertion is sampled synchronously; first FETCH request two cycles after release.

Verification
REQ-038 Reset release, imem_ready_in=1, iaddr_in=fetch_pc+4, instr_ready_in=1 -> requests 0x0,0x4,0x8 back-to-back; pc_out 0x0 valid one cycle after first completion.
REQ-039 instr_ready_in=0, memory always ready -> two entries (0x0,0x4) buffered, imem_req_out=0 (WAIT_SPACE); one pop -> request for 0x8 next cycle.
REQ-040 Request to 0x10 held with imem_ready_in=0, flush_in=1 with iaddr_in=0x200 -> DRAIN, req on 0x10 held; on ready data dropped, next request 0x200, no entry for 0x10.
REQ-041 imem_err_in=1 on completion at 0x24 -> entry pc_out=0x24, fault_out=1; fetch continues at iaddr_in.
REQ-042 iaddr_in=0x102 loaded -> no bus request; entry pc_out=0x102, fault_out=1, instr_out=0x00000013.
REQ-043 Simultaneous push, pop and count=1 -> count stays 1, ordering preserved; flush with pop same cycle -> count=0.

Source files
------------

// File: rtl/msrv32_ifetch_buffer.sv
// Instruction fetch unit: drives the instruction-memory request and holds
// fetched words in a two-entry buffer for decode, with branch/trap redirects.
module msrv32_ifetch_buffer #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH        = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] iaddr_in,
    input  logic        flush_in,
    output logic [31:0] fetch_pc_out,
    output logic        ahb_ready_out,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        imem_err_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        fault_out,
    output logic        instr_valid_out,
    input  logic        instr_ready_in
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH      = 2'd1,
        WAIT_SPACE = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    localparam logic [1:0]  FULL = 2'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        boot_armed_r;
    logic [31:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [31:0] redirect_r, redirect_nxt_s;
    logic [31:0] pc_mem_r    [0:1];
    logic [31:0] instr_mem_r [0:1];
    logic        fault_mem_r [0:1];
    logic        wr_ptr_r, rd_ptr_r;
    logic [1:0]  count_r, count_nxt_s;
    logic        misaligned_s, complete_s, pop_s, push_s, clear_s, ahb_ready_s;

    // Next-state, fetch address and buffer control decisions
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        redirect_nxt_s = redirect_r;
        ahb_ready_s    = 1'b0;
        push_s         = 1'b0;
        clear_s        = 1'b0;
        misaligned_s   = is_misaligned(fetch_pc_r);
        // A misaligned address is never put on the bus; it completes at once.
        complete_s     = (state_r == FETCH) && (misaligned_s || imem_ready_in);
        pop_s          = (count_r != 2'd0) && instr_ready_in && !flush_in;
        case (state_r)
            IDLE: begin
                if (boot_armed_r) begin
                    state_nxt_s = FETCH;
                    if (flush_in) begin
                        fetch_pc_nxt_s = iaddr_in;
                        ahb_ready_s    = 1'b1;
                    end else begin
                        fetch_pc_nxt_s = fetch_pc_r;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (flush_in) begin
                    clear_s = 1'b1;
                    if (complete_s) begin
                        fetch_pc_nxt_s = iaddr_in;
                        ahb_ready_s    = 1'b1;
                        state_nxt_s    = FETCH;
                    end else begin
                        redirect_nxt_s = iaddr_in;
                        state_nxt_s    = DRAIN;
                    end
                end else if (complete_s) begin
                    push_s         = 1'b1;
                    fetch_pc_nxt_s = iaddr_in;
                    ahb_ready_s    = 1'b1;
                    state_nxt_s    = ((count_r + 2'd1 - {1'b0, pop_s}) < FULL) ? FETCH : WAIT_SPACE;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            WAIT_SPACE: begin
                if (flush_in) begin
                    clear_s        = 1'b1;
                    fetch_pc_nxt_s = iaddr_in;
                    ahb_ready_s    = 1'b1;
                    state_nxt_s    = FETCH;
                end else if (pop_s) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = WAIT_SPACE;
                end
            end
            DRAIN: begin
                clear_s = flush_in;
                // The abandoned transfer must finish before the redirect target is issued.
                if (imem_ready_in) begin
                    fetch_pc_nxt_s = flush_in ? iaddr_in : redirect_r;
                    ahb_ready_s    = 1'b1;
                    state_nxt_s    = FETCH;
                end else if (flush_in) begin
                    redirect_nxt_s = iaddr_in;
                    state_nxt_s    = DRAIN;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (clear_s) begin
            count_nxt_s = 2'd0;
        end else begin
            count_nxt_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // State, fetch address, redirect target and buffer storage
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= IDLE;
            boot_armed_r <= 1'b0;
            fetch_pc_r   <= BOOT_ADDRESS;
            redirect_r   <= 32'h0000_0000;
            count_r      <= 2'd0;
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
                fault_mem_r[i] <= 1'b0;
            end
        end else begin
            state_r      <= state_nxt_s;
            boot_armed_r <= 1'b1;
            fetch_pc_r   <= fetch_pc_nxt_s;
            redirect_r   <= redirect_nxt_s;
            count_r      <= count_nxt_s;
            if (push_s) begin
                pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
                instr_mem_r[wr_ptr_r] <= misaligned_s ? NOP : imem_rdata_in;
                fault_mem_r[wr_ptr_r] <= imem_err_in | misaligned_s;
            end else begin
                pc_mem_r[wr_ptr_r] <= pc_mem_r[wr_ptr_r];
            end
            if (clear_s) begin
                wr_ptr_r <= 1'b0;
                rd_ptr_r <= 1'b0;
            end else begin
                wr_ptr_r <= wr_ptr_r ^ push_s;
                rd_ptr_r <= rd_ptr_r ^ pop_s;
            end
        end
    end

    assign fetch_pc_out    = fetch_pc_r;
    assign imem_addr_out   = fetch_pc_r;
    assign imem_req_out    = ((state_r == FETCH) && !misaligned_s) || (state_r == DRAIN);
    assign ahb_ready_out   = ahb_ready_s;
    assign instr_valid_out = count_r != 2'd0;
    assign instr_out       = instr_valid_out ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign pc_out          = instr_valid_out ? pc_mem_r[rd_ptr_r]    : 32'h0000_0000;
    assign fault_out       = instr_valid_out ? fault_mem_r[rd_ptr_r] : 1'b0;

endmodule

// File: tb/tb_msrv32_ifetch_buffer.sv
// Randomised bench for msrv32_ifetch_buffer: a queue-based fetch model predicts
// bus activity and the instruction stream handed to decode.
module tb_msrv32_ifetch_buffer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] iaddr_in;
    logic        flush_in;
    logic [31:0] fetch_pc_out;
    logic        ahb_ready_out;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic [31:0] imem_rdata_in;
    logic        imem_err_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        fault_out;
    logic        instr_valid_out;
    logic        instr_ready_in;

    int checks = 0;
    int errors = 0;

    entry_t      model_q[$];
    entry_t      sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_redirect;
    logic        m_drain;
    int          idle_left;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign imem_rdata_in = mem_word(imem_addr_out);

    msrv32_ifetch_buffer #(.BOOT_ADDRESS(BOOT), .DEPTH(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .iaddr_in(iaddr_in), .flush_in(flush_in),
        .fetch_pc_out(fetch_pc_out), .ahb_ready_out(ahb_ready_out),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ready_in(imem_ready_in), .imem_rdata_in(imem_rdata_in), .imem_err_in(imem_err_in),
        .instr_out(instr_out), .pc_out(pc_out), .fault_out(fault_out),
        .instr_valid_out(instr_valid_out), .instr_ready_in(instr_ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Asynchronous reset mid-cycle, output check, then release between edges
    task automatic reset_and_release();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        flush_in = 1'b0; instr_ready_in = 1'b0; imem_ready_in = 1'b0; imem_err_in = 1'b0;
        #1;
        chk("rst_fetch_pc", fetch_pc_out, BOOT);
        chk("rst_imem_addr", imem_addr_out, BOOT);
        chk("rst_req", {31'd0, imem_req_out}, 32'd0);
        chk("rst_ahb", {31'd0, ahb_ready_out}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid_out}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_fault", {31'd0, fault_out}, 32'd0);
        model_q.delete();
        sb.delete();
        m_pc = BOOT; m_redirect = 32'd0; m_drain = 1'b0; idle_left = 2;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    task automatic drive_random();
        int r;
        r = $urandom_range(0, 99);
        if (r < 75)      iaddr_in = m_pc + 32'd4;
        else if (r < 90) iaddr_in = 32'($urandom_range(0, 1023)) << 2;
        else             iaddr_in = (32'($urandom_range(0, 4095)) & ~32'd3) | 32'($urandom_range(1, 3));
        flush_in       = ($urandom_range(0, 9) == 0);
        imem_ready_in  = ($urandom_range(0, 2) != 0);
        imem_err_in    = ($urandom_range(0, 7) == 0);
        instr_ready_in = ($urandom_range(0, 1) == 1);
    endtask

    // Compare the cycle's outputs against the model, then advance the model by one edge
    task automatic model_step();
        logic exp_req, exp_ahb, mis, comp;
        entry_t e;
        chk("fetch_pc", fetch_pc_out, m_pc);
        chk("imem_addr", imem_addr_out, m_pc);
        chk("instr_valid", {31'd0, instr_valid_out}, {31'd0, model_q.size() > 0});
        if (model_q.size() == 0) begin
            chk("empty_instr", instr_out, 32'd0);
            chk("empty_pc", pc_out, 32'd0);
            chk("empty_fault", {31'd0, fault_out}, 32'd0);
        end
        exp_req = 1'b0;
        exp_ahb = 1'b0;
        mis = m_pc[1:0] != 2'b00;
        if (idle_left == 2) begin
            idle_left = 1;
        end else if (idle_left == 1) begin
            idle_left = 0;
            if (flush_in) begin
                m_pc = iaddr_in; exp_ahb = 1'b1;
            end
        end else if (m_drain) begin
            exp_req = 1'b1;
            if (flush_in) model_q.delete();
            if (imem_ready_in) begin
                m_pc = flush_in ? iaddr_in : m_redirect;
                exp_ahb = 1'b1;
                m_drain = 1'b0;
            end else if (flush_in) begin
                m_redirect = iaddr_in;
            end
        end else if (model_q.size() < 2) begin
            exp_req = !mis;
            comp = mis || imem_ready_in;
            if (flush_in) begin
                model_q.delete();
                if (comp) begin
                    m_pc = iaddr_in; exp_ahb = 1'b1;
                end else begin
                    m_redirect = iaddr_in; m_drain = 1'b1;
                end
            end else begin
                if (model_q.size() > 0 && instr_ready_in) sb.push_back(model_q.pop_front());
                if (comp) begin
                    e.pc = m_pc;
                    e.instr = mis ? 32'h0000_0013 : mem_word(m_pc);
                    e.fault = mis | imem_err_in;
                    model_q.push_back(e);
                    m_pc = iaddr_in;
                    exp_ahb = 1'b1;
                end
            end
        end else begin
            if (flush_in) begin
                model_q.delete(); m_pc = iaddr_in; exp_ahb = 1'b1;
            end else if (instr_ready_in) begin
                sb.push_back(model_q.pop_front());
            end
        end
        chk("imem_req", {31'd0, imem_req_out}, {31'd0, exp_req});
        chk("ahb_ready", {31'd0, ahb_ready_out}, {31'd0, exp_ahb});
    endtask

    // Monitor: every decode acceptance must match the oldest predicted entry
    initial begin
        entry_t e;
        forever begin
            @(negedge clk_in); #1;
            if (rst_in === 1'b1 && instr_valid_out && instr_ready_in && !flush_in) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pop: got pc 0x%08h, expected no entry", pc_out);
                end else begin
                    e = sb.pop_front();
                    chk("pop_pc", pc_out, e.pc);
                    chk("pop_instr", instr_out, e.instr);
                    chk("pop_fault", {31'd0, fault_out}, {31'd0, e.fault});
                end
            end
        end
    end

    initial begin
        rst_in = 1'b0; iaddr_in = 32'd0; flush_in = 1'b0;
        imem_ready_in = 1'b0; imem_err_in = 1'b0; instr_ready_in = 1'b0;
        m_pc = BOOT; m_redirect = 32'd0; m_drain = 1'b0; idle_left = 2;
        reset_and_release();
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) begin
                reset_and_release();
            end
            drive_random();
            @(negedge clk_in);
            model_step();
            @(posedge clk_in); #1;
        end
        flush_in = 1'b0; instr_ready_in = 1'b0;
        @(negedge clk_in); #2;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
